multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multicycle sequencer for the processor datapath: a state machine that drives one shared ALU and one shared memory port across FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK cycles.
- Consumes the instruction-register contents, the ALU zero flag and a memory ready handshake.
- Emits per-cycle datapath control: PC/IR enables, memory strobes, register-file write, mux selects, ALU op.
- Replaces the single-cycle combinational decoder in the multicycle processor top.

Parameters:
- MEM_WAIT_MAX, 255: maximum cycles spent waiting on mem_ready in any memory state before bus error; 0 disables the timeout.
- STATE_W, 4: width of the state register and the state debug output.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- instr  in  32  instruction register contents (opcode [31:26], func [5:0])
- alu_zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  load PC
- pc_src  out  2  0=ALU result (PC+4), 1=branch target register, 2=jump {PC[31:28],addr26,2'b00}
- ir_write  out  1  load instruction register from memory read data
- iord  out  1  memory address select: 0=PC, 1=ALU out
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- reg_write  out  1  register-file write enable
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  write data select: 0=ALU out, 1=memory data register
- alu_src_a  out  1  0=PC, 1=data_a
- alu_src  out  2  0=data_b, 1=sext imm16, 2=zext imm16, 3=constant 4
- alu_op  out  3  ALU operation code (shared constants)
- target_write  out  1  latch ALU result into branch target register
- halted  out  1  sticky; set in HALT
- bus_err  out  1  sticky; memory timeout
- state  out  STATE_W  current state, debug

Behaviour:
- Reset:
  - state=FETCH; wait counter=0; halted=0; bus_err=0.
  - All strobes/enables are 0 during the reset cycle.
  - Reset mid-access abandons the access; no write is issued in the reset cycle.
- Outputs are a decode of the current state. Exception: in FETCH, ir_write and pc_write assert only in the cycle where mem_ready=1.
- Unlisted outputs are 0 in every state.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src=3, alu_op=ADD, pc_src=0.
  - mem_ready=0: stay in FETCH.
  - mem_ready=1: ir_write=1, pc_write=1, go to DECODE.
- DECODE:
  - Outputs: alu_src_a=0, alu_src=1, alu_op=ADD, target_write=1. The imm16 shift by 2 is done by the datapath.
  - Next state: R-type→EXEC_R; ADDI/ANDI/ORI→EXEC_I; LW/SW→MEM_ADDR; BEQ/BNE→BRANCH; J→JUMP; unimplemented→see optional feature.
- EXEC_R:
  - Outputs: alu_src_a=1, alu_src=0, alu_op from func (ADD/AND/OR/NOR/SLT/SLL).
  - Next state: WB_R.
- WB_R: same ALU controls as EXEC_R, plus reg_dst=1, reg_write=1, mem_to_reg=0. Next: FETCH.
- EXEC_I:
  - Outputs: alu_src_a=1; alu_src=1 for ADDI, 2 for ANDI/ORI; alu_op per opcode.
  - Next state: WB_I.
- WB_I: same controls as EXEC_I, plus reg_dst=0, reg_write=1. Next: FETCH.
- MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src=1, alu_op=ADD.
  - Next state: MEM_RD for LW, MEM_WR for SW.
- MEM_RD: iord=1, mem_read=1, ALU address controls held. Wait for mem_ready, then go to WB_MEM.
- MEM_WR: iord=1, mem_write=1, ALU address controls held. Wait for mem_ready, then go to FETCH.
- WB_MEM: reg_dst=0, mem_to_reg=1, reg_write=1. Next: FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src=0, alu_op=SUB, pc_src=1.
  - pc_write=alu_zero for BEQ, ~alu_zero for BNE.
  - Next state: FETCH.
- JUMP: pc_src=2, pc_write=1. Next: FETCH.
- HALT: all strobes 0, halted=1. Only reset exits.
- Latency with mem_ready tied 1:
  - R-type/ALU-immediate: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ/BNE/J: 3 cycles.
  - Each extra wait cycle adds 1.
- Wait counter:
  - Cleared on entry to FETCH/MEM_RD/MEM_WR and on mem_ready.
  - Increments, saturating, each cycle in those states while mem_ready=0.
  - If MEM_WAIT_MAX≠0 and counter reaches MEM_WAIT_MAX with mem_ready still 0: go to HALT, set bus_err.
  - mem_ready in the same cycle as the limit wins; the access completes normally.
- instr is sampled only in DECODE and in the states after it. Changes to instr during FETCH wait cycles are ignored.

Optional Feature:
- Macro MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined: an unimplemented opcode or R-type func in DECODE goes to HALT with halted=1.
- Undefined: it executes as a NOP (DECODE→FETCH, no writes); halted is reachable only via bus_err.

Decomposition:
- Shared include (_const.v) holds:
  - opcode/func constants and ALU_SRC_* constants (extended with ALU_SRC_FOUR=3);
  - OP_* ALU codes (add OP_SUB if absent);
  - new ST_* state encodings and PC_SRC_* constants.
- One sub-module, mc_instr_class: combinational decode of opcode/func into an instruction class plus alu_op. It is shared with any future pipelined control.

Test Plan:
- Reset, then addi $2,$1,5 with mem_ready=1 → states FETCH,DECODE,EXEC_I,WB_I; reg_write=1 only in cycle 4 with reg_dst=0, alu_src=1; pc_write only in cycle 1.
- add $3,$1,$2 with mem_ready held 0 for 3 cycles in FETCH → ir_write/pc_write assert exactly once, in cycle 4; total 7 cycles; WB_R has reg_dst=1.
- lw $4,8($1) then sw $4,8($1) → LW takes 5 cycles with mem_to_reg=1 in WB_MEM; SW has mem_write=1 and iord=1 in cycle 4 and no reg_write anywhere.
- beq with alu_zero=1, then alu_zero=0 → pc_write=1 with pc_src=1 in cycle 3 for the first, pc_write=0 for the second; j → pc_src=2, pc_write=1 in cycle 3.
- MEM_WAIT_MAX=4, mem_ready stuck 0 in MEM_RD → HALT after 4 wait cycles, bus_err=halted=1, all strobes 0 until reset. Repeat with mem_ready=1 in the 4th cycle → normal completion.
- Unimplemented opcode → with MULTICYCLE_ILLEGAL_TRAP_EN: HALT in cycle 3; without: FETCH in cycle 3, no writes. Reset asserted during MEM_WR → next state FETCH, mem_write=0 in the reset cycle.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle processor control path.
// Holds opcode/func encodings, ALU operand-select codes, ALU operation
// codes, PC source selects, the sequencer state encoding and the
// instruction class produced by mc_instr_class.
package multicycle_control_pkg;

  // Opcode field instr[31:26]
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // Func field instr[5:0] for R-type
  localparam logic [5:0] FUNC_SLL = 6'h00;
  localparam logic [5:0] FUNC_ADD = 6'h20;
  localparam logic [5:0] FUNC_AND = 6'h24;
  localparam logic [5:0] FUNC_OR  = 6'h25;
  localparam logic [5:0] FUNC_NOR = 6'h27;
  localparam logic [5:0] FUNC_SLT = 6'h2A;

  // ALU operand B select
  localparam logic [1:0] ALU_SRC_B    = 2'd0;
  localparam logic [1:0] ALU_SRC_SEXT = 2'd1;
  localparam logic [1:0] ALU_SRC_ZEXT = 2'd2;
  localparam logic [1:0] ALU_SRC_FOUR = 2'd3;

  // ALU operation codes
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_NOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_TARGET = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_WB_R     = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_WB_I     = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_MEM_WR   = 4'd8,
    ST_WB_MEM   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_HALT     = 4'd12
  } mc_state_e;

  typedef enum logic [2:0] {
    IC_RTYPE   = 3'd0,
    IC_ALUI    = 3'd1,
    IC_LOAD    = 3'd2,
    IC_STORE   = 3'd3,
    IC_BEQ     = 3'd4,
    IC_BNE     = 3'd5,
    IC_JUMP    = 3'd6,
    IC_ILLEGAL = 3'd7
  } instr_class_e;

endpackage

// File: rtl/mc_instr_class.sv
// Combinational instruction classifier, reusable by other control styles.
// Ports:
//   opcode   in  6  instr[31:26]
//   func     in  6  instr[5:0]
//   iclass   out    instruction class (IC_ILLEGAL for anything unsupported)
//   alu_op   out 3  ALU operation for the execute step
//   imm_zext out 1  immediate is zero-extended (logical immediates)
module mc_instr_class
  import multicycle_control_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   func,
  output instr_class_e iclass,
  output logic [2:0]   alu_op,
  output logic         imm_zext
);

  always_comb begin
    iclass   = IC_ILLEGAL;
    alu_op   = OP_ADD;
    imm_zext = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        iclass = IC_RTYPE;
        case (func)
          FUNC_ADD: alu_op = OP_ADD;
          FUNC_AND: alu_op = OP_AND;
          FUNC_OR:  alu_op = OP_OR;
          FUNC_NOR: alu_op = OP_NOR;
          FUNC_SLT: alu_op = OP_SLT;
          FUNC_SLL: alu_op = OP_SLL;
          default:  iclass = IC_ILLEGAL;
        endcase
      end
      OPC_ADDI: iclass = IC_ALUI;
      OPC_ANDI: begin
        iclass   = IC_ALUI;
        alu_op   = OP_AND;
        imm_zext = 1'b1;
      end
      OPC_ORI: begin
        iclass   = IC_ALUI;
        alu_op   = OP_OR;
        imm_zext = 1'b1;
      end
      OPC_LW:  iclass = IC_LOAD;
      OPC_SW:  iclass = IC_STORE;
      OPC_BEQ: iclass = IC_BEQ;
      OPC_BNE: iclass = IC_BNE;
      OPC_J:   iclass = IC_JUMP;
      default: iclass = IC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle sequencer driving a shared ALU and a shared memory port.
// Optional feature macro: MULTICYCLE_ILLEGAL_TRAP_EN
//   defined   -> unimplemented instruction halts the core
//   undefined -> unimplemented instruction retires as a NOP
// Ports:
//   clk, reset (sync, active-high), instr, alu_zero, mem_ready    inputs
//   pc_write, pc_src, ir_write, iord, mem_read, mem_write,
//   reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src, alu_op,
//   target_write                                     datapath control
//   halted, bus_err (sticky status), state (debug)   outputs
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 255,
  parameter int STATE_W      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr,
  input  logic               alu_zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               ir_write,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src,
  output logic [2:0]         alu_op,
  output logic               target_write,
  output logic               halted,
  output logic               bus_err,
  output logic [STATE_W-1:0] state
);

  localparam int CNT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  // Counter value during the last permitted wait cycle; a miss here times out.
  localparam logic [CNT_W-1:0] WAIT_LIMIT =
    CNT_W'((MEM_WAIT_MAX == 0) ? 0 : MEM_WAIT_MAX - 1);

  mc_state_e        state_q, state_n;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_n;
  logic             halted_q, bus_err_q;
  logic             halt_set, bus_err_set;
  logic             mem_wait_st, timeout;

  instr_class_e     iclass;
  logic [2:0]       cls_alu_op;
  logic             cls_imm_zext;
  logic             unused_instr_bits;

  assign unused_instr_bits = ^instr[25:6];

  mc_instr_class u_instr_class (
    .opcode   (instr[31:26]),
    .func     (instr[5:0]),
    .iclass   (iclass),
    .alu_op   (cls_alu_op),
    .imm_zext (cls_imm_zext)
  );

  assign mem_wait_st = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) ||
                       (state_q == ST_MEM_WR);
  assign timeout = (MEM_WAIT_MAX != 0) && mem_wait_st && !mem_ready &&
                   (wait_cnt_q == WAIT_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      wait_cnt_q <= '0;
      halted_q   <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_n;
      wait_cnt_q <= wait_cnt_n;
      if (halt_set)    halted_q  <= 1'b1;
      if (bus_err_set) bus_err_q <= 1'b1;
    end
  end

  // Counts only while lingering in a memory state; any transition clears it.
  always_comb begin
    wait_cnt_n = '0;
    if (mem_wait_st && !mem_ready && (state_n == state_q))
      wait_cnt_n = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
  end

  always_comb begin
    state_n      = state_q;
    halt_set     = 1'b0;
    bus_err_set  = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_ALU;
    ir_write     = 1'b0;
    iord         = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = 1'b0;
    alu_src      = ALU_SRC_B;
    alu_op       = OP_ADD;
    target_write = 1'b0;
    // Reset is synchronous, so the decode is suppressed for the whole
    // reset cycle to keep an interrupted access from issuing a strobe.
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          mem_read = 1'b1;
          alu_src  = ALU_SRC_FOUR;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_n  = ST_DECODE;
          end else if (timeout) begin
            halt_set    = 1'b1;
            bus_err_set = 1'b1;
            state_n     = ST_HALT;
          end
        end
        ST_DECODE: begin
          alu_src      = ALU_SRC_SEXT;
          target_write = 1'b1;
          case (iclass)
            IC_RTYPE:          state_n = ST_EXEC_R;
            IC_ALUI:           state_n = ST_EXEC_I;
            IC_LOAD, IC_STORE: state_n = ST_MEM_ADDR;
            IC_BEQ, IC_BNE:    state_n = ST_BRANCH;
            IC_JUMP:           state_n = ST_JUMP;
            default: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
              halt_set = 1'b1;
              state_n  = ST_HALT;
`else
              state_n  = ST_FETCH;
`endif
            end
          endcase
        end
        ST_EXEC_R, ST_WB_R: begin
          alu_src_a = 1'b1;
          alu_op    = cls_alu_op;
          if (state_q == ST_WB_R) begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
            state_n   = ST_FETCH;
          end else begin
            state_n   = ST_WB_R;
          end
        end
        ST_EXEC_I, ST_WB_I: begin
          alu_src_a = 1'b1;
          alu_src   = cls_imm_zext ? ALU_SRC_ZEXT : ALU_SRC_SEXT;
          alu_op    = cls_alu_op;
          if (state_q == ST_WB_I) begin
            reg_write = 1'b1;
            state_n   = ST_FETCH;
          end else begin
            state_n   = ST_WB_I;
          end
        end
        ST_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src   = ALU_SRC_SEXT;
          state_n   = (iclass == IC_STORE) ? ST_MEM_WR :
                      (iclass == IC_LOAD)  ? ST_MEM_RD : ST_FETCH;
        end
        ST_MEM_RD, ST_MEM_WR: begin
          iord      = 1'b1;
          alu_src_a = 1'b1;
          alu_src   = ALU_SRC_SEXT;
          mem_read  = (state_q == ST_MEM_RD);
          mem_write = (state_q == ST_MEM_WR);
          if (mem_ready) begin
            state_n = (state_q == ST_MEM_RD) ? ST_WB_MEM : ST_FETCH;
          end else if (timeout) begin
            halt_set    = 1'b1;
            bus_err_set = 1'b1;
            state_n     = ST_HALT;
          end
        end
        ST_WB_MEM: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          state_n    = ST_FETCH;
        end
        ST_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = OP_SUB;
          pc_src    = PC_SRC_TARGET;
          pc_write  = (iclass == IC_BNE) ? ~alu_zero : alu_zero;
          state_n   = ST_FETCH;
        end
        ST_JUMP: begin
          pc_src   = PC_SRC_JUMP;
          pc_write = 1'b1;
          state_n  = ST_FETCH;
        end
        ST_HALT: state_n = ST_HALT;
        default: state_n = ST_FETCH;
      endcase
    end
  end

  assign halted  = halted_q;
  assign bus_err = bus_err_q;
  assign state   = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control (MEM_WAIT_MAX=4).
// Each table row is one clock cycle: inputs driven after the falling edge,
// state and control outputs compared 1 time unit later.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = '0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, ir_write, iord, mem_read, mem_write, reg_write;
  logic        reg_dst, mem_to_reg, alu_src_a, target_write, halted, bus_err;
  logic [1:0]  pc_src, alu_src;
  logic [2:0]  alu_op;
  logic [3:0]  state;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_WAIT_MAX(4), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .instr(instr), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src(alu_src),
    .alu_op(alu_op), .target_write(target_write), .halted(halted),
    .bus_err(bus_err), .state(state)
  );

  logic [18:0] obs;
  assign obs = {pc_write, pc_src, ir_write, iord, mem_read, mem_write,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src, alu_op,
                target_write, halted, bus_err};

  function automatic logic [18:0] cv(
    input logic pcw, input logic [1:0] pcs, input logic irw, input logic io,
    input logic mr, input logic mw, input logic rw, input logic rd,
    input logic m2r, input logic asa, input logic [1:0] asrc,
    input logic [2:0] aop, input logic tw, input logic h, input logic be);
    return {pcw, pcs, irw, io, mr, mw, rw, rd, m2r, asa, asrc, aop, tw, h, be};
  endfunction

  typedef struct {
    logic        rst;
    logic        chk;
    logic [31:0] ins;
    logic        rdy;
    logic        zero;
    logic [3:0]  st;
    logic [18:0] ctl;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic rst, input logic chk, input logic [31:0] ins,
                     input logic rdy, input logic zero, input mc_state_e st,
                     input logic [18:0] ctl);
    vec_t v;
    v.rst = rst; v.chk = chk; v.ins = ins; v.rdy = rdy; v.zero = zero;
    v.st = st; v.ctl = ctl;
    tbl.push_back(v);
  endtask

  task automatic check1(input string name, input logic [31:0] got,
                        input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  initial begin
    logic [31:0] i_addi, i_ori, i_add, i_slt, i_lw, i_sw, i_beq, i_bne, i_j;
    logic [31:0] i_ill;
    logic [18:0] c_z, c_fw, c_fg, c_dec, c_exi, c_wbi, c_exo, c_wbo, c_exr;
    logic [18:0] c_wbr, c_exs, c_wbs, c_ma, c_mrd, c_mwr, c_wbm, c_bt, c_bn;
    logic [18:0] c_j, c_hb, c_trap;
    int n;

    i_addi = {6'h08, 5'd1, 5'd2, 16'd5};
    i_ori  = {6'h0D, 5'd1, 5'd5, 16'h00FF};
    i_add  = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
    i_slt  = {6'h00, 5'd1, 5'd2, 5'd6, 5'd0, 6'h2A};
    i_lw   = {6'h23, 5'd1, 5'd4, 16'd8};
    i_sw   = {6'h2B, 5'd1, 5'd4, 16'd8};
    i_beq  = {6'h04, 5'd1, 5'd2, 16'd3};
    i_bne  = {6'h05, 5'd1, 5'd2, 16'd3};
    i_j    = {6'h02, 26'h10};
    i_ill  = {6'h3F, 26'h0};

    //            pcw pcs  irw io mr mw rw rd m2r asa asrc  aop     tw h be
    c_z    = '0;
    c_fw   = cv(N, 2'd0, N, N, Y, N, N, N, N, N, 2'd3, OP_ADD, N, N, N);
    c_fg   = cv(Y, 2'd0, Y, N, Y, N, N, N, N, N, 2'd3, OP_ADD, N, N, N);
    c_dec  = cv(N, 2'd0, N, N, N, N, N, N, N, N, 2'd1, OP_ADD, Y, N, N);
    c_exi  = cv(N, 2'd0, N, N, N, N, N, N, N, Y, 2'd1, OP_ADD, N, N, N);
    c_wbi  = cv(N, 2'd0, N, N, N, N, Y, N, N, Y, 2'd1, OP_ADD, N, N, N);
    c_exo  = cv(N, 2'd0, N, N, N, N, N, N, N, Y, 2'd2, OP_OR,  N, N, N);
    c_wbo  = cv(N, 2'd0, N, N, N, N, Y, N, N, Y, 2'd2, OP_OR,  N, N, N);
    c_exr  = cv(N, 2'd0, N, N, N, N, N, N, N, Y, 2'd0, OP_ADD, N, N, N);
    c_wbr  = cv(N, 2'd0, N, N, N, N, Y, Y, N, Y, 2'd0, OP_ADD, N, N, N);
    c_exs  = cv(N, 2'd0, N, N, N, N, N, N, N, Y, 2'd0, OP_SLT, N, N, N);
    c_wbs  = cv(N, 2'd0, N, N, N, N, Y, Y, N, Y, 2'd0, OP_SLT, N, N, N);
    c_ma   = cv(N, 2'd0, N, N, N, N, N, N, N, Y, 2'd1, OP_ADD, N, N, N);
    c_mrd  = cv(N, 2'd0, N, Y, Y, N, N, N, N, Y, 2'd1, OP_ADD, N, N, N);
    c_mwr  = cv(N, 2'd0, N, Y, N, Y, N, N, N, Y, 2'd1, OP_ADD, N, N, N);
    c_wbm  = cv(N, 2'd0, N, N, N, N, Y, N, Y, N, 2'd0, 3'd0,   N, N, N);
    c_bt   = cv(Y, 2'd1, N, N, N, N, N, N, N, Y, 2'd0, OP_SUB, N, N, N);
    c_bn   = cv(N, 2'd1, N, N, N, N, N, N, N, Y, 2'd0, OP_SUB, N, N, N);
    c_j    = cv(Y, 2'd2, N, N, N, N, N, N, N, N, 2'd0, 3'd0,   N, N, N);
    c_hb   = cv(N, 2'd0, N, N, N, N, N, N, N, N, 2'd0, 3'd0,   N, Y, Y);
    c_trap = cv(N, 2'd0, N, N, N, N, N, N, N, N, 2'd0, 3'd0,   N, Y, N);

    // reset state
    add(Y, Y, 32'h0, N, N, ST_FETCH, c_z);
    // addi $2,$1,5
    add(N, Y, i_addi, Y, N, ST_FETCH,  c_fg);
    add(N, Y, i_addi, Y, N, ST_DECODE, c_dec);
    add(N, Y, i_addi, Y, N, ST_EXEC_I, c_exi);
    add(N, Y, i_addi, Y, N, ST_WB_I,   c_wbi);
    // ori: zero-extended immediate
    add(N, Y, i_ori, Y, N, ST_FETCH,  c_fg);
    add(N, Y, i_ori, Y, N, ST_DECODE, c_dec);
    add(N, Y, i_ori, Y, N, ST_EXEC_I, c_exo);
    add(N, Y, i_ori, Y, N, ST_WB_I,   c_wbo);
    // add $3,$1,$2 with three fetch wait cycles; instr changes meanwhile
    add(N, Y, i_ill,        N, N, ST_FETCH,  c_fw);
    add(N, Y, 32'hFFFFFFFF, N, N, ST_FETCH,  c_fw);
    add(N, Y, i_ori,        N, N, ST_FETCH,  c_fw);
    add(N, Y, i_add,        Y, N, ST_FETCH,  c_fg);
    add(N, Y, i_add,        Y, N, ST_DECODE, c_dec);
    add(N, Y, i_add,        Y, N, ST_EXEC_R, c_exr);
    add(N, Y, i_add,        Y, N, ST_WB_R,   c_wbr);
    // slt: alu_op from func
    add(N, Y, i_slt, Y, N, ST_FETCH,  c_fg);
    add(N, Y, i_slt, Y, N, ST_DECODE, c_dec);
    add(N, Y, i_slt, Y, N, ST_EXEC_R, c_exs);
    add(N, Y, i_slt, Y, N, ST_WB_R,   c_wbs);
    // lw then sw
    add(N, Y, i_lw, Y, N, ST_FETCH,    c_fg);
    add(N, Y, i_lw, Y, N, ST_DECODE,   c_dec);
    add(N, Y, i_lw, Y, N, ST_MEM_ADDR, c_ma);
    add(N, Y, i_lw, Y, N, ST_MEM_RD,   c_mrd);
    add(N, Y, i_lw, Y, N, ST_WB_MEM,   c_wbm);
    add(N, Y, i_sw, Y, N, ST_FETCH,    c_fg);
    add(N, Y, i_sw, Y, N, ST_DECODE,   c_dec);
    add(N, Y, i_sw, Y, N, ST_MEM_ADDR, c_ma);
    add(N, Y, i_sw, Y, N, ST_MEM_WR,   c_mwr);
    // branches and jump
    add(N, Y, i_beq, Y, Y, ST_FETCH,  c_fg);
    add(N, Y, i_beq, Y, Y, ST_DECODE, c_dec);
    add(N, Y, i_beq, Y, Y, ST_BRANCH, c_bt);
    add(N, Y, i_beq, Y, N, ST_FETCH,  c_fg);
    add(N, Y, i_beq, Y, N, ST_DECODE, c_dec);
    add(N, Y, i_beq, Y, N, ST_BRANCH, c_bn);
    add(N, Y, i_bne, Y, N, ST_FETCH,  c_fg);
    add(N, Y, i_bne, Y, N, ST_DECODE, c_dec);
    add(N, Y, i_bne, Y, N, ST_BRANCH, c_bt);
    add(N, Y, i_j,   Y, N, ST_FETCH,  c_fg);
    add(N, Y, i_j,   Y, N, ST_DECODE, c_dec);
    add(N, Y, i_j,   Y, N, ST_JUMP,   c_j);
    // lw with memory stuck: four wait cycles then bus error halt
    add(N, Y, i_lw, Y, N, ST_FETCH,    c_fg);
    add(N, Y, i_lw, Y, N, ST_DECODE,   c_dec);
    add(N, Y, i_lw, Y, N, ST_MEM_ADDR, c_ma);
    add(N, Y, i_lw, N, N, ST_MEM_RD,   c_mrd);
    add(N, Y, i_lw, N, N, ST_MEM_RD,   c_mrd);
    add(N, Y, i_lw, N, N, ST_MEM_RD,   c_mrd);
    add(N, Y, i_lw, N, N, ST_MEM_RD,   c_mrd);
    add(N, Y, i_lw, Y, N, ST_HALT,     c_hb);
    add(N, Y, i_lw, Y, N, ST_HALT,     c_hb);
    add(Y, N, i_lw, N, N, ST_HALT,     c_z);
    // lw with ready arriving in the last permitted wait cycle
    add(N, Y, i_lw, Y, N, ST_FETCH,    c_fg);
    add(N, Y, i_lw, Y, N, ST_DECODE,   c_dec);
    add(N, Y, i_lw, Y, N, ST_MEM_ADDR, c_ma);
    add(N, Y, i_lw, N, N, ST_MEM_RD,   c_mrd);
    add(N, Y, i_lw, N, N, ST_MEM_RD,   c_mrd);
    add(N, Y, i_lw, N, N, ST_MEM_RD,   c_mrd);
    add(N, Y, i_lw, Y, N, ST_MEM_RD,   c_mrd);
    add(N, Y, i_lw, Y, N, ST_WB_MEM,   c_wbm);
    // unimplemented opcode
    add(N, Y, i_ill, Y, N, ST_FETCH,  c_fg);
    add(N, Y, i_ill, Y, N, ST_DECODE, c_dec);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    add(N, Y, i_ill, N, N, ST_HALT,   c_trap);
`else
    add(N, Y, i_ill, N, N, ST_FETCH,  c_fw);
`endif
    add(Y, N, i_ill, N, N, ST_FETCH,  c_z);
    // reset in the middle of a store
    add(N, Y, i_sw, Y, N, ST_FETCH,    c_fg);
    add(N, Y, i_sw, Y, N, ST_DECODE,   c_dec);
    add(N, Y, i_sw, Y, N, ST_MEM_ADDR, c_ma);
    add(N, Y, i_sw, N, N, ST_MEM_WR,   c_mwr);
    add(Y, Y, i_sw, Y, N, ST_MEM_WR,   c_z);
    add(N, Y, i_sw, N, N, ST_FETCH,    c_fw);

    foreach (tbl[i]) begin
      @(negedge clk);
      reset     = tbl[i].rst;
      instr     = tbl[i].ins;
      mem_ready = tbl[i].rdy;
      alu_zero  = tbl[i].zero;
      #1;
      if (tbl[i].chk) begin
        checks++;
        if (state !== tbl[i].st) begin
          errors++;
          $display("FAIL row%0d state got=%0d want=%0d", i, state, tbl[i].st);
        end
        checks++;
        if (obs !== tbl[i].ctl) begin
          errors++;
          $display("FAIL row%0d ctl got=%b want=%b", i, obs, tbl[i].ctl);
        end
      end
    end

    // Fetch timeout: memory never answers an instruction fetch.
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n = 0;
    while (state === 4'(ST_FETCH) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check1("fetch_wait_cycles", n, 4);
    check1("fetch_to_state", {28'h0, state}, {28'h0, ST_HALT});
    check1("fetch_bus_err", {31'h0, bus_err}, 32'd1);
    check1("fetch_halted", {31'h0, halted}, 32'd1);
    check1("halt_strobes", {13'h0, obs}, {13'h0, c_hb});

    // Reset clears sticky status.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check1("post_reset_state", {28'h0, state}, {28'h0, ST_FETCH});
    check1("post_reset_halted", {31'h0, halted}, 32'd0);
    check1("post_reset_bus_err", {31'h0, bus_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
